// File: rtl/addsub20_slice_seq_if.sv
// Operand and result handshake bundle for the sliced add/subtract sequencer.
// The master side issues operands and consumes results; the slave side is the sequencer.
interface addsub20_slice_seq_if #(
    parameter int WIDTH = 20
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, result, carry_out, overflow
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, result, carry_out, overflow
    );
endinterface

// File: rtl/addsub20_slice_seq.sv
// Streams WIDTH-bit add/subtract operands LSB-first through one external SLICE-bit CLA slice,
// chaining the carry in a register and assembling the result over NSLICE cycles.
module addsub20_slice_seq #(
    parameter int WIDTH  = 20,
    parameter int SLICE  = 5,
    localparam int NSLICE = WIDTH / SLICE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    addsub20_slice_seq_if.slave   bus,
    output logic [SLICE-1:0]      slice_a,
    output logic [SLICE-1:0]      slice_b,
    output logic                  slice_cin,
    input  logic [SLICE-1:0]      slice_sum,
    input  logic                  slice_carry,
    input  logic                  slice_overflow
);
    localparam int IDXW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [IDXW-1:0]  idx;
    logic             carry_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] result_q;
    logic             carry_out_q;
    logic             overflow_q;

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.result    = result_q;
    assign bus.carry_out = carry_out_q;
    assign bus.overflow  = overflow_q;

    // The slice only sees live operands while running; it is held at zero otherwise.
    always_comb begin
        slice_a   = '0;
        slice_b   = '0;
        slice_cin = 1'b0;
        if (state == RUN) begin
            slice_a   = a_q[idx*SLICE +: SLICE];
            slice_b   = b_q[idx*SLICE +: SLICE];
            slice_cin = carry_q;
        end
    end

    // Subtraction is folded in at accept time: B is inverted and the +1 rides in as the first carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b ^ {WIDTH{bus.sub}};
                        carry_q <= bus.sub;
                        idx     <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    result_q[idx*SLICE +: SLICE] <= slice_sum;
                    carry_q                      <= slice_carry;
                    if (idx == IDXW'(NSLICE - 1)) begin
                        carry_out_q <= slice_carry;
                        overflow_q  <= slice_overflow;
                        idx         <= '0;
                        state       <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
